// File: rtl/tx_initiated_point_test_rx.sv
// Partner-die responder for the TX-initiated D2C point test; responses registered on state entry,
// held until sideband TX finishes (busy negedge while RX idle). Optional error counter: TX_PT_RX_ERRCNT_EN.
module tx_initiated_point_test_rx #(
  parameter int NUM_LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [3:0]           i_sideband_message,
  input  logic                 i_sideband_message_valid,
  input  logic [15:0]          i_sideband_data,
  input  logic [NUM_LANES-1:0] i_lane_error,
  input  logic                 i_error_valid,
  input  logic                 i_busy_negedge_detected,
  input  logic                 i_valid_rx,
  output logic [3:0]           o_sideband_message,
  output logic                 o_valid_tx,
  output logic [15:0]          o_sideband_data,
  output logic                 o_data_valid,
  output logic                 o_comparator_clear,
  output logic                 o_mainband_compare_en,
  output logic                 o_val_compare_en,
  output logic                 o_test_ack_rx
);

  localparam logic [3:0] REQ_START  = 4'b0001;
  localparam logic [3:0] REQ_CLEAR  = 4'b0011;
  localparam logic [3:0] REQ_RESULT = 4'b0101;
  localparam logic [3:0] REQ_END    = 4'b0111;
  localparam logic [3:0] RSP_START  = 4'b0010;
  localparam logic [3:0] RSP_CLEAR  = 4'b0100;
  localparam logic [3:0] RSP_RESULT = 4'b0110;
  localparam logic [3:0] RSP_END    = 4'b1000;

  typedef enum logic [3:0] {
    IDLE, WAIT_START, START_RESP, WAIT_CLEAR, CLEAR_RESP,
    COMPARE, RESULT_RESP, WAIT_END, END_RESP, FINISHED
  } state_t;

  state_t state, state_nxt;
  logic [NUM_LANES-1:0] acc, acc_nxt;
  logic                 psel, psel_nxt;
  logic [3:0]           msg_nxt;
  logic                 vtx_nxt, dv_nxt, clr_nxt, mb_nxt, val_nxt, ack_nxt;
  logic [15:0]          data_nxt;
  logic [15:0]          mask;
  logic                 send_done;
  logic                 unused_data;

  assign unused_data = ^i_sideband_data[15:1];

`ifdef TX_PT_RX_ERRCNT_EN
  logic [11:0] cnt, cnt_nxt;
  logic [4:0]  pop;
  logic [12:0] cnt_sum;
`endif

  // Pending response is released only when our own message finished and RX is not holding the bus.
  assign send_done = o_valid_tx && i_busy_negedge_detected && !i_valid_rx;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    psel_nxt  = psel;
    msg_nxt   = o_sideband_message;
    vtx_nxt   = o_valid_tx;
    data_nxt  = o_sideband_data;
    dv_nxt    = o_data_valid;
    clr_nxt   = 1'b0;
    mb_nxt    = o_mainband_compare_en;
    val_nxt   = o_val_compare_en;
    ack_nxt   = o_test_ack_rx;
    mask      = '0;
`ifdef TX_PT_RX_ERRCNT_EN
    cnt_nxt = cnt;
    pop     = '0;
    cnt_sum = '0;
`endif

    if (!i_en) begin
      state_nxt = IDLE;
      msg_nxt   = '0;
      vtx_nxt   = 1'b0;
      data_nxt  = '0;
      dv_nxt    = 1'b0;
      mb_nxt    = 1'b0;
      val_nxt   = 1'b0;
      ack_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = WAIT_START;
        WAIT_START: if (i_sideband_message_valid && i_sideband_message == REQ_START) begin
          psel_nxt  = i_sideband_data[0];
          msg_nxt   = RSP_START;
          vtx_nxt   = 1'b1;
          state_nxt = START_RESP;
        end
        START_RESP: if (send_done) begin
          msg_nxt   = '0;
          vtx_nxt   = 1'b0;
          state_nxt = WAIT_CLEAR;
        end
        WAIT_CLEAR: if (i_sideband_message_valid && i_sideband_message == REQ_CLEAR) begin
          clr_nxt   = 1'b1;
          acc_nxt   = '0;
`ifdef TX_PT_RX_ERRCNT_EN
          cnt_nxt   = '0;
`endif
          msg_nxt   = RSP_CLEAR;
          vtx_nxt   = 1'b1;
          state_nxt = CLEAR_RESP;
        end
        CLEAR_RESP: if (send_done) begin
          msg_nxt   = '0;
          vtx_nxt   = 1'b0;
          mb_nxt    = !psel;
          val_nxt   = psel;
          state_nxt = COMPARE;
        end
        COMPARE: begin
          if (i_error_valid) begin
            acc_nxt = acc | i_lane_error;
`ifdef TX_PT_RX_ERRCNT_EN
            for (int i = 0; i < NUM_LANES; i++) pop = pop + {4'b0, i_lane_error[i]};
            cnt_sum = {1'b0, cnt} + {8'b0, pop};
            cnt_nxt = cnt_sum[12] ? 12'hFFF : cnt_sum[11:0];
`endif
          end
          // The mask uses acc_nxt so an error sample coincident with the request still counts.
          if (i_sideband_message_valid && i_sideband_message == REQ_RESULT) begin
            mask[NUM_LANES-1:0] = ~acc_nxt;
`ifdef TX_PT_RX_ERRCNT_EN
            data_nxt = psel ? {cnt_nxt, 4'b0} : mask;
`else
            data_nxt = psel ? {15'b0, ~acc_nxt[0]} : mask;
`endif
            mb_nxt    = 1'b0;
            val_nxt   = 1'b0;
            msg_nxt   = RSP_RESULT;
            vtx_nxt   = 1'b1;
            dv_nxt    = 1'b1;
            state_nxt = RESULT_RESP;
          end
        end
        RESULT_RESP: if (send_done) begin
          msg_nxt   = '0;
          vtx_nxt   = 1'b0;
          dv_nxt    = 1'b0;
          data_nxt  = '0;
          state_nxt = WAIT_END;
        end
        WAIT_END: if (i_sideband_message_valid && i_sideband_message == REQ_END) begin
          msg_nxt   = RSP_END;
          vtx_nxt   = 1'b1;
          state_nxt = END_RESP;
        end
        END_RESP: if (send_done) begin
          msg_nxt   = '0;
          vtx_nxt   = 1'b0;
          ack_nxt   = 1'b1;
          state_nxt = FINISHED;
        end
        FINISHED: state_nxt = FINISHED;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      acc                   <= '0;
      psel                  <= 1'b0;
      o_sideband_message    <= '0;
      o_valid_tx            <= 1'b0;
      o_sideband_data       <= '0;
      o_data_valid          <= 1'b0;
      o_comparator_clear    <= 1'b0;
      o_mainband_compare_en <= 1'b0;
      o_val_compare_en      <= 1'b0;
      o_test_ack_rx         <= 1'b0;
`ifdef TX_PT_RX_ERRCNT_EN
      cnt                   <= '0;
`endif
    end else begin
      state                 <= state_nxt;
      acc                   <= acc_nxt;
      psel                  <= psel_nxt;
      o_sideband_message    <= msg_nxt;
      o_valid_tx            <= vtx_nxt;
      o_sideband_data       <= data_nxt;
      o_data_valid          <= dv_nxt;
      o_comparator_clear    <= clr_nxt;
      o_mainband_compare_en <= mb_nxt;
      o_val_compare_en      <= val_nxt;
      o_test_ack_rx         <= ack_nxt;
`ifdef TX_PT_RX_ERRCNT_EN
      cnt                   <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tx_initiated_point_test_rx.sv
// Directed bench for tx_initiated_point_test_rx: full handshake sequences with hand-computed responses.
module tb_tx_initiated_point_test_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [3:0]  i_sideband_message;
  logic        i_sideband_message_valid;
  logic [15:0] i_sideband_data;
  logic [15:0] i_lane_error;
  logic        i_error_valid;
  logic        i_busy_negedge_detected;
  logic        i_valid_rx;
  logic [3:0]  o_sideband_message;
  logic        o_valid_tx;
  logic [15:0] o_sideband_data;
  logic        o_data_valid;
  logic        o_comparator_clear;
  logic        o_mainband_compare_en;
  logic        o_val_compare_en;
  logic        o_test_ack_rx;

  int errors = 0;
  int checks = 0;

  tx_initiated_point_test_rx #(.NUM_LANES(16)) dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .i_sideband_message(i_sideband_message),
    .i_sideband_message_valid(i_sideband_message_valid),
    .i_sideband_data(i_sideband_data),
    .i_lane_error(i_lane_error), .i_error_valid(i_error_valid),
    .i_busy_negedge_detected(i_busy_negedge_detected), .i_valid_rx(i_valid_rx),
    .o_sideband_message(o_sideband_message), .o_valid_tx(o_valid_tx),
    .o_sideband_data(o_sideband_data), .o_data_valid(o_data_valid),
    .o_comparator_clear(o_comparator_clear),
    .o_mainband_compare_en(o_mainband_compare_en),
    .o_val_compare_en(o_val_compare_en), .o_test_ack_rx(o_test_ack_rx)
  );

  always #5 clk = ~clk;

  logic [25:0] all_out;
  assign all_out = {o_sideband_message, o_valid_tx, o_sideband_data, o_data_valid,
                    o_comparator_clear, o_mainband_compare_en, o_val_compare_en, o_test_ack_rx};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] code, input logic [15:0] data);
    i_sideband_message       = code;
    i_sideband_data          = data;
    i_sideband_message_valid = 1'b1;
    step();
    i_sideband_message_valid = 1'b0;
    i_sideband_message       = 4'h0;
    i_sideband_data          = 16'h0;
  endtask

  task automatic busy(input logic rx);
    i_busy_negedge_detected = 1'b1;
    i_valid_rx              = rx;
    step();
    i_busy_negedge_detected = 1'b0;
    i_valid_rx              = 1'b0;
  endtask

  task automatic run_to_compare(input logic [15:0] start_data);
    i_en = 1'b1;
    step();
    req(4'b0001, start_data);
    busy(1'b0);
    req(4'b0011, 16'h0);
    busy(1'b0);
  endtask

  task automatic finish_and_disable();
    req(4'b0111, 16'h0);
    busy(1'b0);
    i_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_en = 1'b0; i_sideband_message = 4'h0; i_sideband_message_valid = 1'b0;
    i_sideband_data = 16'h0; i_lane_error = 16'h0; i_error_valid = 1'b0;
    i_busy_negedge_detected = 1'b0; i_valid_rx = 1'b0;
    step(); step();
    checks++;
    if (all_out !== 26'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_out, 26'h0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_mainband();
    i_en = 1'b1;
    step();
    req(4'b0001, 16'h0000);
    checks++;
    if ({o_sideband_message, o_valid_tx, o_data_valid} !== {4'b0010, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_resp: got %b expected %b", {o_sideband_message, o_valid_tx, o_data_valid}, 6'b0010_1_0);
    end
    step();
    checks++;
    if (o_valid_tx !== 1'b1) begin
      errors++; $display("FAIL start_resp_held: got %b expected 1", o_valid_tx);
    end
    busy(1'b0);
    checks++;
    if ({o_sideband_message, o_valid_tx} !== 5'b0000_0) begin
      errors++; $display("FAIL start_resp_release: got %b expected 00000", {o_sideband_message, o_valid_tx});
    end
    req(4'b0011, 16'h0);
    checks++;
    if ({o_comparator_clear, o_sideband_message, o_valid_tx} !== {1'b1, 4'b0100, 1'b1}) begin
      errors++; $display("FAIL clear_resp: got %b expected 1_0100_1", {o_comparator_clear, o_sideband_message, o_valid_tx});
    end
    step();
    checks++;
    if (o_comparator_clear !== 1'b0) begin
      errors++; $display("FAIL clear_pulse_width: got %b expected 0", o_comparator_clear);
    end
    busy(1'b0);
    checks++;
    if ({o_mainband_compare_en, o_val_compare_en} !== 2'b10) begin
      errors++; $display("FAIL mainband_enable: got %b expected 10", {o_mainband_compare_en, o_val_compare_en});
    end
    req(4'b0101, 16'h0);
    checks++;
    if ({o_sideband_message, o_valid_tx, o_data_valid, o_sideband_data, o_mainband_compare_en}
        !== {4'b0110, 1'b1, 1'b1, 16'hFFFF, 1'b0}) begin
      errors++; $display("FAIL clean_result: msg %b vtx %b dv %b data %h mb %b expected 0110 1 1 ffff 0",
                         o_sideband_message, o_valid_tx, o_data_valid, o_sideband_data, o_mainband_compare_en);
    end
    busy(1'b0);
    checks++;
    if ({o_data_valid, o_sideband_data} !== 17'h0) begin
      errors++; $display("FAIL result_release: got %h expected 0", {o_data_valid, o_sideband_data});
    end
    req(4'b0111, 16'h0);
    checks++;
    if ({o_sideband_message, o_valid_tx} !== 5'b1000_1) begin
      errors++; $display("FAIL end_resp: got %b expected 10001", {o_sideband_message, o_valid_tx});
    end
    busy(1'b0);
    step();
    checks++;
    if ({o_test_ack_rx, o_valid_tx} !== 2'b10) begin
      errors++; $display("FAIL test_ack: got %b expected 10", {o_test_ack_rx, o_valid_tx});
    end
    i_en = 1'b0;
    step();
    checks++;
    if (o_test_ack_rx !== 1'b0) begin
      errors++; $display("FAIL ack_drop_on_disable: got %b expected 0", o_test_ack_rx);
    end
  endtask

  task automatic test_lane_errors();
    i_en = 1'b1;
    step();
    req(4'b0001, 16'h0);
    busy(1'b0);
    req(4'b0011, 16'h0);
    // error sample outside COMPARE must not accumulate
    i_lane_error = 16'h0002; i_error_valid = 1'b1;
    step();
    i_error_valid = 1'b0;
    busy(1'b0);
    i_lane_error = 16'h0004; i_error_valid = 1'b1; step();
    i_lane_error = 16'h0001; i_error_valid = 1'b0; step();
    i_lane_error = 16'h8004; i_error_valid = 1'b1; step();
    i_lane_error = 16'h0000; i_error_valid = 1'b0;
    req(4'b0101, 16'h0);
    checks++;
    if ({o_sideband_data, o_data_valid, o_valid_tx} !== {16'h7FFB, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lane_error_mask: data %h dv %b vtx %b expected 7ffb 1 1",
                         o_sideband_data, o_data_valid, o_valid_tx);
    end
    busy(1'b0);
    finish_and_disable();
  endtask

  task automatic test_valtrain();
    logic [15:0] exp_data;
`ifdef TX_PT_RX_ERRCNT_EN
    exp_data = 16'h0010;
`else
    exp_data = 16'h0000;
`endif
    run_to_compare(16'h0019);
    checks++;
    if ({o_val_compare_en, o_mainband_compare_en} !== 2'b10) begin
      errors++; $display("FAIL valtrain_enable: got %b expected 10", {o_val_compare_en, o_mainband_compare_en});
    end
    // lane0 error coincides with the result request
    i_lane_error = 16'h0001; i_error_valid = 1'b1;
    req(4'b0101, 16'h0);
    i_lane_error = 16'h0000; i_error_valid = 1'b0;
    checks++;
    if ({o_sideband_data, o_data_valid, o_val_compare_en} !== {exp_data, 1'b1, 1'b0}) begin
      errors++; $display("FAIL valtrain_result: data %h dv %b val_en %b expected %h 1 0",
                         o_sideband_data, o_data_valid, o_val_compare_en, exp_data);
    end
    busy(1'b0);
    finish_and_disable();
  endtask

  task automatic test_priority_and_order();
    i_en = 1'b1;
    step();
    req(4'b0001, 16'h0);
    busy(1'b1);
    checks++;
    if ({o_valid_tx, o_sideband_message} !== 5'b1_0010) begin
      errors++; $display("FAIL rx_priority_hold: got %b expected 10010", {o_valid_tx, o_sideband_message});
    end
    busy(1'b0);
    checks++;
    if (o_valid_tx !== 1'b0) begin
      errors++; $display("FAIL rx_priority_release: got %b expected 0", o_valid_tx);
    end
    req(4'b0101, 16'h0);
    checks++;
    if ({o_valid_tx, o_sideband_message, o_data_valid} !== 6'b0) begin
      errors++; $display("FAIL out_of_order_ignored: got %b expected 000000", {o_valid_tx, o_sideband_message, o_data_valid});
    end
    req(4'b0011, 16'h0);
    checks++;
    if ({o_comparator_clear, o_sideband_message} !== 5'b1_0100) begin
      errors++; $display("FAIL clear_after_ignore: got %b expected 10100", {o_comparator_clear, o_sideband_message});
    end
    busy(1'b0);
  endtask

  task automatic test_abort();
    i_lane_error = 16'h00F0; i_error_valid = 1'b1; step();
    i_lane_error = 16'h0000; i_error_valid = 1'b0;
    i_sideband_message = 4'b0101; i_sideband_message_valid = 1'b1; i_en = 1'b0;
    step();
    i_sideband_message = 4'h0; i_sideband_message_valid = 1'b0;
    checks++;
    if (all_out !== 26'h0) begin
      errors++; $display("FAIL abort_outputs: got %h expected %h", all_out, 26'h0);
    end
    run_to_compare(16'h0000);
    req(4'b0101, 16'h0);
    checks++;
    if (o_sideband_data !== 16'hFFFF) begin
      errors++; $display("FAIL rerun_clean_acc: got %h expected ffff", o_sideband_data);
    end
    busy(1'b0);
    finish_and_disable();
  endtask

  task automatic test_reset_mid_test();
    run_to_compare(16'h0001);
    rst = 1'b1;
    step();
    checks++;
    if (all_out !== 26'h0) begin
      errors++; $display("FAIL mid_test_reset: got %h expected %h", all_out, 26'h0);
    end
    rst = 1'b0;
    i_en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_clean_mainband();
    test_lane_errors();
    test_valtrain();
    test_priority_and_order();
    test_abort();
    test_reset_mid_test();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
